axi_burst_master: RTL and testbench
===================================

Name: axi_burst_master

Overview:
AXI4 initiator that turns single command-queue requests into one INCR read or write burst on an AXI4 master port. Local side: a command channel, a write-data stream and a read-data stream, plus a status channel reporting per-command completion. Used by test harnesses and DMA-style engines to drive AXI4 RAM responders in the same design. One transaction in flight at a time.

Parameters:
DATA_WIDTH, 32, AXI data width in bits
ADDR_WIDTH, 16, AXI address width in bits
STRB_WIDTH, DATA_WIDTH/8, byte lanes; must be a power of two
ID_WIDTH, 8, AXI ID width
AXI_ID, 0, fixed ID driven on AWID and ARID

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
cmd_addr / cmd_len / cmd_write  in  ADDR_WIDTH / 8 / 1  byte address, beats-1, 1=write 0=read
cmd_valid / cmd_ready  in / out  1 / 1  command handshake
wr_data / wr_strb  in  DATA_WIDTH / STRB_WIDTH  write beat payload
wr_valid / wr_ready  in / out  1 / 1  write-data handshake
rd_data / rd_last  out  DATA_WIDTH / 1  read beat payload, last-beat flag
rd_valid / rd_ready  out / in  1 / 1  read-data handshake
sts_resp / sts_write  out  2 / 1  completion response, command type
sts_valid / sts_ready  out / in  1 / 1  status handshake
m_axi_awid/awaddr/awlen/awsize/awburst/awvalid  out  ID/ADDR/8/3/2/1  write address channel
m_axi_awready  in  1
m_axi_wdata/wstrb/wlast/wvalid  out  DATA/STRB/1/1; m_axi_wready in 1
m_axi_bid/bresp/bvalid  in  ID/2/1; m_axi_bready out 1
m_axi_arid/araddr/arlen/arsize/arburst/arvalid  out  ID/ADDR/8/3/2/1; m_axi_arready in 1
m_axi_rid/rdata/rresp/rlast/rvalid  in  ID/DATA/2/1/1; m_axi_rready out 1
m_axi_awlock/awcache/awprot, m_axi_arlock/arcache/arprot  out  1/4/3  constant 0 / 4'b0011 / 3'b000

Behaviour:
- States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, STS.
- Reset (rst_n=0 at edge): state IDLE. cmd_ready, sts_valid, awvalid, wvalid, bready, arvalid, rready, rd_valid, wr_ready all 0. sts_resp=0. cmd_ready goes to 1 on the first cycle after reset is released.
- Reset mid-burst aborts immediately with no bus cleanup. The responder must also be reset.
- IDLE: cmd_ready=1 (registered). On cmd_valid&&cmd_ready, capture the command and drop cmd_ready.
- Command check: the command is rejected if cmd_addr low log2(STRB_WIDTH) bits are nonzero, or if cmd_addr[11:0] + (cmd_len+1)*STRB_WIDTH > 4096 (4 KB crossing). A rejected command goes to STS with sts_resp=2'b10 and generates no AXI traffic.
- Accepted write goes to WADDR; accepted read goes to RADDR.
- AXI fields: awsize/arsize = log2(STRB_WIDTH), burst = 2'b01 INCR, len = cmd_len, addr = cmd_addr.
- WADDR/RADDR: awvalid/arvalid asserted the cycle after acceptance and held stable until the matching ready; then go to WDATA/RDATA.
- WDATA: combinational pass-through. m_axi_wvalid = wr_valid, wr_ready = m_axi_wready, data and strb forwarded. An 8-bit beat counter loads cmd_len. wlast=1 when counter==0. After the last beat transfers, go to WRESP.
- WRESP: bready=1. On bvalid, latch bresp; sts_resp = bresp, or 2'b10 if bid != AXI_ID. Go to STS.
- RDATA: pass-through. rd_valid = m_axi_rvalid, m_axi_rready = rd_ready, rd_data/rd_last forwarded. Latch the first non-OKAY rresp. The burst ends on the beat with rlast. If rlast arrives at any counter value other than 0, or counter reaches 0 without rlast, sts_resp=2'b10. Go to STS.
- STS: sts_valid=1, sts_write = command type, hold until sts_ready; then IDLE, with cmd_ready=1 the next cycle.
- Minimum latency: command accepted at cycle N → AW/AR valid at N+1.
- Minimum write throughput: len+1 beats in len+1 cycles with wready and wr_valid held high.
- cmd_len=0 gives a single beat with wlast/rlast on the first beat.
- No new command is accepted while any state other than IDLE is active.

Optional Feature:
AXI_BURST_MASTER_STATS_EN:
- Defined: adds outputs stat_wr_count, stat_rd_count, stat_err_count (32 bits each). They increment on each completed write, completed read, and status with sts_resp != 0, respectively. Counted at the sts_valid&&sts_ready handshake, including rejected commands. They wrap modulo 2^32 and clear on reset.
- Undefined: the ports and logic are absent.

Test Plan:
- Write addr 0x0100, len 3, data 0x11..0x44, strb 0xF → AW len=3, size=2, burst=1; wlast on beat 4; bresp 0 → sts_resp=0, sts_write=1.
- Read the same burst, with rd_ready toggled 1/0 each cycle → rd_data 0x11,0x22,0x33,0x44 in order; rd_last only on the 4th beat; sts_resp=0.
- Command addr 0x0FF8, len 3, DATA_WIDTH 32 (crosses 4 KB) → no AWVALID ever; sts_resp=2'b10 within 2 cycles.
- Command addr 0x0102 (misaligned) read → rejected, sts_resp=2'b10; next command accepted normally.
- Responder asserts rlast on beat 2 of a len=3 read → burst ends, sts_resp=2'b10, state IDLE afterward.
- Assert rst_n=0 for one cycle mid write burst → all valids 0 next cycle; cmd_ready=1 one cycle after release; a fresh write completes OKAY (stats counters read 0 before it when AXI_BURST_MASTER_STATS_EN is defined).

Source files
------------

// File: rtl/axi_burst_master_if.sv
// axi_burst_master_if: AXI4 master-port bundle (AW/W/B/AR/R channels) used by axi_burst_master.
interface axi_burst_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_burst_master.sv
// axi_burst_master: turns one queued command into a single AXI4 INCR burst, one transaction in flight.
// Define AXI_BURST_MASTER_STATS_EN to add completed-write/read/error counters.
module axi_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int AXI_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic                  cmd_write,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [1:0]            sts_resp,
    output logic                  sts_write,
    output logic                  sts_valid,
    input  logic                  sts_ready,
`ifdef AXI_BURST_MASTER_STATS_EN
    output logic [31:0]           stat_wr_count,
    output logic [31:0]           stat_rd_count,
    output logic [31:0]           stat_err_count,
`endif
    axi_burst_master_if.master    m_axi
);
    localparam logic [2:0] SIZE = 3'($clog2(STRB_WIDTH));

    typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, STS} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q, cnt;
    logic                  write_q;
    logic [1:0]            resp_q;
    logic [31:0]           span;
    logic                  reject, cmd_fire, w_fire, b_fire, r_fire;

    // Reject misaligned starts and bursts whose last byte falls past the 4 KB page
    assign span     = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * 32'(STRB_WIDTH);
    assign reject   = (|(cmd_addr & ADDR_WIDTH'(STRB_WIDTH - 1))) || span > 32'd4096;
    assign cmd_fire = cmd_valid && cmd_ready;
    assign w_fire   = state == WDATA && wr_valid && m_axi.wready;
    assign b_fire   = state == WRESP && m_axi.bvalid;
    assign r_fire   = state == RDATA && m_axi.rvalid && rd_ready;

    assign m_axi.awid    = ID_WIDTH'(AXI_ID);
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_q;
    assign m_axi.awsize  = SIZE;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.arid    = ID_WIDTH'(AXI_ID);
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = SIZE;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.wdata   = wr_data;
    assign m_axi.wstrb   = wr_strb;
    assign m_axi.wlast   = cnt == 8'd0;
    assign rd_data       = m_axi.rdata;
    assign rd_last       = m_axi.rlast;
    assign sts_resp      = resp_q;
    assign sts_write     = write_q;

    always_comb begin
        state_nx      = state;
        m_axi.awvalid = state == WADDR;
        m_axi.arvalid = state == RADDR;
        m_axi.wvalid  = state == WDATA && wr_valid;
        wr_ready      = state == WDATA && m_axi.wready;
        m_axi.bready  = state == WRESP;
        rd_valid      = state == RDATA && m_axi.rvalid;
        m_axi.rready  = state == RDATA && rd_ready;
        sts_valid     = state == STS;
        case (state)
            IDLE:    if (cmd_fire) state_nx = reject ? STS : cmd_write ? WADDR : RADDR;
            WADDR:   if (m_axi.awready) state_nx = WDATA;
            WDATA:   if (w_fire && cnt == 8'd0) state_nx = WRESP;
            WRESP:   if (b_fire) state_nx = STS;
            RADDR:   if (m_axi.arready) state_nx = RDATA;
            RDATA:   if (r_fire && (m_axi.rlast || cnt == 8'd0)) state_nx = STS;
            STS:     if (sts_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            resp_q    <= 2'b00;
            write_q   <= 1'b0;
            cnt       <= 8'd0;
        end else begin
            state     <= state_nx;
            cmd_ready <= state_nx == IDLE;
            if (cmd_fire) begin
                addr_q  <= cmd_addr;
                len_q   <= cmd_len;
                cnt     <= cmd_len;
                write_q <= cmd_write;
                resp_q  <= reject ? 2'b10 : 2'b00;
            end
            if (w_fire) cnt <= cnt - 8'd1;
            if (b_fire) resp_q <= m_axi.bid != ID_WIDTH'(AXI_ID) ? 2'b10 : m_axi.bresp;
            // rlast out of step with the beat count is a protocol error and wins over rresp
            if (r_fire) begin
                cnt <= cnt - 8'd1;
                if (m_axi.rlast != (cnt == 8'd0)) resp_q <= 2'b10;
                else if (resp_q == 2'b00) resp_q <= m_axi.rresp;
            end
        end
    end

`ifdef AXI_BURST_MASTER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_wr_count  <= 32'd0;
            stat_rd_count  <= 32'd0;
            stat_err_count <= 32'd0;
        end else if (sts_valid && sts_ready) begin
            if (write_q) stat_wr_count <= stat_wr_count + 32'd1;
            else stat_rd_count <= stat_rd_count + 32'd1;
            if (resp_q != 2'b00) stat_err_count <= stat_err_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: directed vector table plus hand sequences against a small AXI4 RAM responder.
module tb_axi_burst_master;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        cmd_write, cmd_valid, cmd_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic [1:0]  sts_resp;
    logic        sts_write, sts_valid, sts_ready;
`ifdef AXI_BURST_MASTER_STATS_EN
    logic [31:0] stat_wr_count, stat_rd_count, stat_err_count;
`endif

    axi_burst_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) bus ();

    axi_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .AXI_ID(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_write(cmd_write),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .sts_resp(sts_resp), .sts_write(sts_write), .sts_valid(sts_valid), .sts_ready(sts_ready),
`ifdef AXI_BURST_MASTER_STATS_EN
        .stat_wr_count(stat_wr_count), .stat_rd_count(stat_rd_count), .stat_err_count(stat_err_count),
`endif
        .m_axi(bus)
    );

    // Responder knobs, set per vector
    logic [1:0] k_bresp = 0, k_rerr = 0;
    logic [7:0] k_bid = 0;
    int         k_rerr_at = -1, k_rlast_at = -1;

    logic [31:0] mem [0:16383];
    logic        aw_rdy, ar_rdy, bv, rbusy;
    logic [13:0] wptr, rptr;
    logic [1:0]  b_r;
    logic [7:0]  b_i, rlen, rbeat, wbeat;
    logic [7:0]  aw_len_q;
    logic [2:0]  aw_size_q, ar_size_q;
    logic [1:0]  aw_burst_q, ar_burst_q;
    logic [3:0]  aw_cache_q, w_strb_q;
    int          aw_n = 0, ar_n = 0, wlast_bad = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_rdy <= 0; ar_rdy <= 0; bv <= 0; rbusy <= 0;
        end else begin
            aw_rdy <= bus.awvalid && !aw_rdy;
            ar_rdy <= bus.arvalid && !ar_rdy;
            if (bus.awvalid && aw_rdy) begin
                wptr <= bus.awaddr[15:2]; wbeat <= 0; aw_n <= aw_n + 1;
                aw_len_q <= bus.awlen; aw_size_q <= bus.awsize;
                aw_burst_q <= bus.awburst; aw_cache_q <= bus.awcache;
            end
            if (bus.wvalid && bus.wready) begin
                for (int b = 0; b < 4; b++) if (bus.wstrb[b]) mem[wptr][8*b +: 8] <= bus.wdata[8*b +: 8];
                wptr <= wptr + 1; wbeat <= wbeat + 1; w_strb_q <= bus.wstrb;
                if (bus.wlast != (wbeat == aw_len_q)) wlast_bad <= wlast_bad + 1;
                if (bus.wlast) begin bv <= 1; b_r <= k_bresp; b_i <= k_bid; end
            end
            if (bv && bus.bready) bv <= 0;
            if (bus.arvalid && ar_rdy) begin
                rptr <= bus.araddr[15:2]; rlen <= bus.arlen; rbeat <= 0; rbusy <= 1; ar_n <= ar_n + 1;
                ar_size_q <= bus.arsize; ar_burst_q <= bus.arburst;
            end
            if (bus.rvalid && bus.rready) begin
                if (bus.rlast) rbusy <= 0;
                rbeat <= rbeat + 1; rptr <= rptr + 1;
            end
        end
    end

    assign bus.awready = aw_rdy;
    assign bus.wready  = 1'b1;
    assign bus.bvalid  = bv;
    assign bus.bresp   = b_r;
    assign bus.bid     = b_i;
    assign bus.arready = ar_rdy;
    assign bus.rvalid  = rbusy;
    assign bus.rdata   = mem[rptr];
    assign bus.rid     = 8'd0;
    assign bus.rresp   = k_rerr_at < 0 ? 2'b00 : int'(rbeat) == k_rerr_at ? k_rerr :
                         int'(rbeat) > k_rerr_at ? 2'b10 : 2'b00;
    assign bus.rlast   = k_rlast_at < 0 ? rbeat == rlen : int'(rbeat) == k_rlast_at;

    // Cycle-level monitor for latency and throughput
    int cyc = 0, acc_cyc = 0, aw_cyc = -1, ar_cyc = -1, wf = -1, wl = -1;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cmd_valid && cmd_ready) begin acc_cyc <= cyc; aw_cyc <= -1; ar_cyc <= -1; wf <= -1; end
        if (bus.awvalid && aw_cyc < 0) aw_cyc <= cyc;
        if (bus.arvalid && ar_cyc < 0) ar_cyc <= cyc;
        if (bus.wvalid && bus.wready) begin if (wf < 0) wf <= cyc; wl <= cyc; end
    end

    typedef struct {
        bit wr; logic [15:0] addr; logic [7:0] len; logic [31:0] seed; logic [3:0] strb;
        logic [1:0] bresp; logic [7:0] bid; int rerr_at; logic [1:0] rerr; int rlast_at;
        bit tog; bit chk_data; logic [1:0] exp_resp; int exp_beats;
    } vec_t;

    function automatic vec_t mk(bit wr, logic [15:0] a, logic [7:0] l, logic [31:0] s, logic [3:0] sb,
                                logic [1:0] br, logic [7:0] bi, int rea, logic [1:0] re, int rla,
                                bit tg, bit cd, logic [1:0] er, int eb);
        vec_t v;
        v.wr = wr; v.addr = a; v.len = l; v.seed = s; v.strb = sb; v.bresp = br; v.bid = bi;
        v.rerr_at = rea; v.rerr = re; v.rlast_at = rla; v.tog = tg; v.chk_data = cd;
        v.exp_resp = er; v.exp_beats = eb;
        return v;
    endfunction

    int n_vec = 0, n_bad = 0;
    int exp_wr = 0, exp_rd = 0, exp_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input vec_t v, output bit acc);
        acc = 0;
        k_bresp = v.bresp; k_bid = v.bid; k_rerr_at = v.rerr_at; k_rerr = v.rerr; k_rlast_at = v.rlast_at;
        @(negedge clk);
        cmd_addr = v.addr; cmd_len = v.len; cmd_write = v.wr; cmd_valid = 1;
        for (int t = 0; t < 20 && !acc; t++) begin
            acc = cmd_ready;
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 0;
    endtask

    task automatic do_cmd(input vec_t v, output logic [1:0] resp, output logic swr, output int beats,
                          output int lat, output bit ok_data, output bit done);
        bit acc;
        send_cmd(v, acc);
        beats = 0; ok_data = 1; done = 0; lat = -1; resp = 2'b00; swr = 0;
        if (acc) begin
            sts_ready = 1;
            for (int t = 0; t < 400 && !done; t++) begin
                wr_valid = v.wr; wr_strb = v.strb; wr_data = v.seed + 32'(beats + 1) * 32'h11;
                rd_ready = !v.tog || t % 2 == 0;
                #1;
                if (wr_valid && wr_ready) beats++;
                if (rd_valid && rd_ready) begin
                    if (v.chk_data && (rd_data !== v.seed + 32'(beats + 1) * 32'h11 ||
                                       rd_last !== (beats == int'(v.len)))) ok_data = 0;
                    beats++;
                end
                if (sts_valid) begin resp = sts_resp; swr = sts_write; lat = t; done = 1; end
                @(posedge clk);
                @(negedge clk);
            end
            wr_valid = 0; rd_ready = 0; sts_ready = 0;
        end
    endtask

    localparam int NV = 15;
    vec_t tab [NV];
    vec_t v;
    logic [1:0] resp;
    logic swr;
    int beats, lat, aw0, ar0, wb0;
    bit ok, done, acc;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            wr addr      len seed   strb  br    bid  rea re    rla tg cd exp   beats
        tab[0]  = mk(1, 16'h0100, 3, 32'h0,   4'hF, 2'b00, 0, -1, 2'b00, -1, 0, 0, 2'b00, 4);
        tab[1]  = mk(0, 16'h0100, 3, 32'h0,   4'hF, 2'b00, 0, -1, 2'b00, -1, 1, 1, 2'b00, 4);
        tab[2]  = mk(1, 16'h0FF8, 3, 32'h0,   4'hF, 2'b00, 0, -1, 2'b00, -1, 0, 0, 2'b10, 0);
        tab[3]  = mk(0, 16'h0FF4, 3, 32'h0,   4'hF, 2'b00, 0, -1, 2'b00, -1, 0, 0, 2'b10, 0);
        tab[4]  = mk(0, 16'h0102, 0, 32'h0,   4'hF, 2'b00, 0, -1, 2'b00, -1, 0, 0, 2'b10, 0);
        tab[5]  = mk(1, 16'h0200, 0, 32'h100, 4'hF, 2'b00, 0, -1, 2'b00, -1, 0, 0, 2'b00, 1);
        tab[6]  = mk(0, 16'h0200, 0, 32'h100, 4'hF, 2'b00, 0, -1, 2'b00, -1, 0, 1, 2'b00, 1);
        tab[7]  = mk(1, 16'h0FF0, 3, 32'h200, 4'hF, 2'b00, 0, -1, 2'b00, -1, 0, 0, 2'b00, 4);
        tab[8]  = mk(0, 16'h0FF0, 3, 32'h200, 4'hF, 2'b00, 0, -1, 2'b00, -1, 0, 1, 2'b00, 4);
        tab[9]  = mk(1, 16'h0300, 1, 32'h300, 4'h6, 2'b01, 0, -1, 2'b00, -1, 0, 0, 2'b01, 2);
        tab[10] = mk(1, 16'h0300, 1, 32'h300, 4'hF, 2'b00, 5, -1, 2'b00, -1, 0, 0, 2'b10, 2);
        tab[11] = mk(0, 16'h0100, 3, 32'h0,   4'hF, 2'b00, 0,  1, 2'b11, -1, 0, 1, 2'b11, 4);
        tab[12] = mk(0, 16'h0100, 3, 32'h0,   4'hF, 2'b00, 0, -1, 2'b00,  1, 0, 0, 2'b10, 2);
        tab[13] = mk(0, 16'h0100, 0, 32'h0,   4'hF, 2'b00, 0, -1, 2'b00, -1, 0, 1, 2'b00, 1);
        tab[14] = mk(0, 16'h0100, 3, 32'h0,   4'hF, 2'b00, 0, -1, 2'b00,  5, 0, 0, 2'b10, 4);

        cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_write = 0;
        wr_valid = 0; wr_data = 0; wr_strb = 4'hF; rd_ready = 0; sts_ready = 0;
        repeat (3) @(negedge clk);
        chk("reset cmd_ready", cmd_ready, 0);
        chk("reset valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready,
                             rd_valid, wr_ready, sts_valid}, 0);
        chk("reset sts_resp", sts_resp, 0);
        rst_n = 1;
        @(negedge clk);
        chk("cmd_ready after release", cmd_ready, 1);

        // Latency and full-rate write throughput
        v = mk(1, 16'h0400, 7, 32'h1000, 4'hF, 2'b00, 0, -1, 2'b00, -1, 0, 0, 2'b00, 8);
        do_cmd(v, resp, swr, beats, lat, ok, done);
        chk("latency aw", aw_cyc - acc_cyc, 1);
        chk("throughput w 8 beats", wl - wf, 7);
        chk("long write resp", resp, 0);
        v = mk(0, 16'h0400, 7, 32'h1000, 4'hF, 2'b00, 0, -1, 2'b00, -1, 0, 1, 2'b00, 8);
        do_cmd(v, resp, swr, beats, lat, ok, done);
        chk("latency ar", ar_cyc - acc_cyc, 1);
        chk("long read data", ok, 1);
        exp_wr = 1; exp_rd = 1;

        for (int k = 0; k < NV; k++) begin
            aw0 = aw_n; ar0 = ar_n; wb0 = wlast_bad;
            do_cmd(tab[k], resp, swr, beats, lat, ok, done);
            chk($sformatf("v%0d done", k), done, 1);
            chk($sformatf("v%0d sts_resp", k), resp, tab[k].exp_resp);
            chk($sformatf("v%0d sts_write", k), swr, tab[k].wr);
            chk($sformatf("v%0d beats", k), beats, tab[k].exp_beats);
            chk($sformatf("v%0d aw count", k), aw_n - aw0, tab[k].wr && tab[k].exp_beats > 0);
            chk($sformatf("v%0d ar count", k), ar_n - ar0, !tab[k].wr && tab[k].exp_beats > 0);
            chk($sformatf("v%0d cmd_ready after sts", k), cmd_ready, 1);
            if (tab[k].exp_beats == 0) chk($sformatf("v%0d reject latency", k), lat <= 1, 1);
            if (tab[k].chk_data) chk($sformatf("v%0d read data/last", k), ok, 1);
            if (tab[k].wr && tab[k].exp_beats > 0) begin
                chk($sformatf("v%0d wlast position", k), wlast_bad - wb0, 0);
                chk($sformatf("v%0d wstrb", k), w_strb_q, tab[k].strb);
            end
            if (k == 0) begin
                chk("awlen", aw_len_q, 3);
                chk("awsize", aw_size_q, 2);
                chk("awburst", aw_burst_q, 1);
                chk("awcache", aw_cache_q, 4'b0011);
            end
            if (k == 1) begin
                chk("arsize", ar_size_q, 2);
                chk("arburst", ar_burst_q, 1);
            end
            if (tab[k].wr) exp_wr++; else exp_rd++;
            if (tab[k].exp_resp != 2'b00) exp_err++;
        end
`ifdef AXI_BURST_MASTER_STATS_EN
        chk("stat_wr_count", stat_wr_count, exp_wr);
        chk("stat_rd_count", stat_rd_count, exp_rd);
        chk("stat_err_count", stat_err_count, exp_err);
`endif

        // Reset in the middle of a write burst
        v = mk(1, 16'h0500, 7, 32'h2000, 4'hF, 2'b00, 0, -1, 2'b00, -1, 0, 0, 2'b00, 8);
        send_cmd(v, acc);
        chk("mid-burst accepted", acc, 1);
        wr_valid = 1; wr_strb = 4'hF; wr_data = 32'h2011;
        repeat (4) @(negedge clk);
        chk("mid-burst wvalid", bus.wvalid, 1);
        rst_n = 0;
        @(negedge clk);
        chk("abort valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready,
                             rd_valid, wr_ready, sts_valid, cmd_ready}, 0);
        rst_n = 1; wr_valid = 0;
        @(negedge clk);
        chk("abort cmd_ready", cmd_ready, 1);
`ifdef AXI_BURST_MASTER_STATS_EN
        chk("abort stats zero", {stat_wr_count | stat_rd_count | stat_err_count}, 0);
`endif
        v = mk(1, 16'h0600, 3, 32'h3000, 4'hF, 2'b00, 0, -1, 2'b00, -1, 0, 0, 2'b00, 4);
        do_cmd(v, resp, swr, beats, lat, ok, done);
        chk("fresh write done", done, 1);
        chk("fresh write resp", resp, 0);
        chk("fresh write beats", beats, 4);
`ifdef AXI_BURST_MASTER_STATS_EN
        chk("fresh stat_wr_count", stat_wr_count, 1);
`endif
        v = mk(0, 16'h0600, 3, 32'h3000, 4'hF, 2'b00, 0, -1, 2'b00, -1, 1, 1, 2'b00, 4);
        do_cmd(v, resp, swr, beats, lat, ok, done);
        chk("fresh read data", ok, 1);
        chk("fresh read resp", resp, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
